cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares the common data bus (CDB) between the execution units (ALU, branch unit, load/store, mult/div) that return results. It grants one requester per cycle using round-robin priority and registers the winner into a single-entry output stage. That stage drives the ROB write port and the reservation-station operand snoop.
The arbiter sits between the execution-unit result outputs and every CDB consumer. It is flushed together with the ROB on misprediction or exception.

Parameters:
EU_N, 4, number of requesters (execution units); >= 2
PTR_LEN, $clog2(EU_N), width of the round-robin priority pointer (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline flush
eu_valid_i  in  EU_N  per-unit result valid
eu_ready_o  out  EU_N  per-unit grant/accept (one-hot or zero)
eu_data_i  in  EU_N x cdb_data_t  per-unit result (rob_idx, value, except_raised, except_code)
cdb_valid_o  out  1  CDB output register holds a result
cdb_ready_i  in  1  all CDB consumers accept (AND of ROB and reservation-station readies)
cdb_data_o  out  cdb_data_t  registered CDB payload

Behaviour:
- Reset (rst_n_i=0, asynchronous): cdb_valid_o=0, cdb_data_o=0, priority pointer=0. eu_ready_o=0 while reset is asserted.
- State:
  - out_valid/out_data register (single entry).
  - prio_ptr (PTR_LEN bits): index of the highest-priority requester.
- Slot free condition: slot_free = !cdb_valid_o || cdb_ready_i. This allows back-to-back transfers every cycle at full throughput.
- Grant (combinational):
  - If slot_free and !flush_i, grant the first i with eu_valid_i[i]=1, searching prio_ptr, prio_ptr+1, ... modulo EU_N.
  - eu_ready_o = grant, at most one bit set.
  - No grant when no valid input, when the slot is not free, or when flush_i=1.
- Transfer: a unit's result is consumed on the edge where eu_valid_i[i] && eu_ready_o[i]. Units must hold valid and data stable until granted. The arbiter never drops a request.
- Latency: exactly 1 cycle from the accept edge to cdb_valid_o=1 with cdb_data_o = the granted unit's eu_data_i.
- Output register update on each edge:
  - grant: load data and set valid.
  - else if cdb_valid_o && cdb_ready_i: clear valid. Data is held; don't care.
  - else: hold.
- Pointer update: on a grant to index g, prio_ptr <= (g == EU_N-1) ? 0 : g+1. The wrap is explicit, so EU_N need not be a power of 2. With no grant, the pointer holds.
- Fairness: a continuously valid requester is granted within EU_N grants.
- Backpressure: while cdb_valid_o=1 and cdb_ready_i=0:
  - cdb_data_o is stable;
  - eu_ready_o=0;
  - the pointer holds.
- Flush (flush_i=1, synchronous):
  - no grant in that cycle;
  - cdb_valid_o <= 0 at the next edge, even if cdb_ready_i=1 (the result is discarded);
  - prio_ptr <= 0.
  - Requesters are flushed by their own logic.
- Simultaneous output pop and new grant in the same cycle: the new data replaces the old and cdb_valid_o stays 1.
- Reset mid-transfer: all state clears immediately. Pending unit requests are not accepted.
- Illegal input: EU_N requesters presenting the same rob_idx is not checked. A simulation-only assertion flags a grant vector that is not one-hot.

Decomposition:
- cdb_data_t already exists in expipe_pkg.
- Add EU_N (the default unit count) and a per-unit index enum to expipe_pkg, so the issue logic and the arbiter share the ordering.
- One sub-module, rr_arbiter: parameter N; inputs clk_i, rst_n_i, flush_i, req_i[N], en_i; output gnt_o[N] one-hot.
  - It contains the pointer register, the rotate/priority-encode logic and the pointer update.
  - It is reusable for the load/store buffer memory-port arbitration.
- cdb_arbiter adds the output register, the payload mux and the handshake logic.

Test Plan:
1. Reset, then EU_N=4 with only eu_valid_i=4'b0100, rob_idx=5, value=0xAB, cdb_ready_i=1 -> eu_ready_o=4'b0100 in that cycle; next cycle cdb_valid_o=1, cdb_data_o.rob_idx=5, value=0xAB; prio_ptr=3.
2. All four valid continuously, cdb_ready_i=1 -> grants in order 0,1,2,3,0,...; one CDB result per cycle; no gaps after the first cycle.
3. cdb_valid_o=1 with cdb_ready_i=0 held 3 cycles while units 1 and 2 request -> eu_ready_o=0 and cdb_data_o stable for those cycles; when ready rises, unit 1 is granted in the same cycle as the pop.
4. Pointer at 3, requests 4'b1001 -> unit 3 granted and the pointer wraps to 0; the next cycle unit 0 is granted.
5. flush_i=1 while cdb_valid_o=1 and units 0 and 2 request -> no grant; next cycle cdb_valid_o=0 and prio_ptr=0.
6. rst_n_i pulsed low mid-backpressure (no clock edge) -> cdb_valid_o drops to 0 immediately and eu_ready_o=0 during reset; after release, the requesting unit with the lowest index is granted.

Source files
------------

// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: CDB result payload and the execution-unit ordering
// used by both the issue logic and the CDB arbiter.
package expipe_pkg;

  localparam int ROB_IDX_W  = 6;
  localparam int VALUE_W    = 32;
  localparam int EXC_CODE_W = 5;

  // Default number of result-producing execution units.
  localparam int EU_N = 4;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [VALUE_W-1:0]    value;
    logic                  except_raised;
    logic [EXC_CODE_W-1:0] except_code;
  } cdb_data_t;

  // Position in this enum is the requester index on the CDB arbiter.
  typedef enum logic [$clog2(EU_N)-1:0] {
    EU_ALU = 2'd0,
    EU_BRU = 2'd1,
    EU_LSU = 2'd2,
    EU_MDU = 2'd3
  } eu_idx_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority pointer, rotated priority search and pointer advance.
// Grants at most one requester per cycle while enabled; flush returns priority to index 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int PTR_LEN = (N > 1) ? $clog2(N) : 1;

  logic [PTR_LEN-1:0] r_ptr;
  logic [PTR_LEN-1:0] w_gnt_idx;
  logic [PTR_LEN-1:0] w_ptr_nxt;
  logic [N-1:0]       w_gnt;
  logic               w_any;
  logic               w_en;

  // Modulo-N add with an explicit wrap so N need not be a power of two.
  function automatic logic [PTR_LEN-1:0] wrap_add(input logic [PTR_LEN-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return s[PTR_LEN-1:0];
  endfunction

  // Reset is folded in so no grant is visible while rst_n_i is low.
  assign w_en = en_i && rst_n_i && !flush_i;

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_en && !w_any && req_i[wrap_add(r_ptr, k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = wrap_add(r_ptr, k);
      end
    end
    if (w_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign w_ptr_nxt = (w_gnt_idx == PTR_LEN'(N - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr <= '0;
    end else if (flush_i) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign gnt_o = w_gnt;

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(gnt_o));

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution-unit result per cycle (round-robin) and
// registers it into a single-entry stage feeding the ROB write port and RS snoop.
module cdb_arbiter
  import expipe_pkg::cdb_data_t;
#(
  parameter int EU_N = expipe_pkg::EU_N
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic [EU_N-1:0] eu_valid_i,
  output logic [EU_N-1:0] eu_ready_o,
  input  cdb_data_t       eu_data_i [EU_N],
  output logic            cdb_valid_o,
  input  logic            cdb_ready_i,
  output cdb_data_t       cdb_data_o
);

  logic            r_valid;
  cdb_data_t       r_data;
  logic            w_slot_free;
  logic [EU_N-1:0] w_gnt;
  cdb_data_t       w_mux;

  // A pop and a new load can share one edge, giving one result per cycle.
  assign w_slot_free = !r_valid || cdb_ready_i;

  rr_arbiter #(
    .N (EU_N)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .req_i   (eu_valid_i),
    .en_i    (w_slot_free),
    .gnt_o   (w_gnt)
  );

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < EU_N; i++) begin
      if (w_gnt[i]) w_mux = eu_data_i[i];
    end
  end

  // Flush discards a held result even when the consumers would have taken it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (|w_gnt) begin
      r_valid <= 1'b1;
      r_data  <= w_mux;
    end else if (r_valid && cdb_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign eu_ready_o  = w_gnt;
  assign cdb_valid_o = r_valid;
  assign cdb_data_o  = r_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: fixed vector table, directed multi-cycle sequences and a
// randomized run against a behavioural round-robin model.
module tb_cdb_arbiter;
  import expipe_pkg::*;

  localparam int N = 4;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      flush = 1'b0;
  logic      cdb_ready = 1'b0;
  logic [N-1:0] eu_valid = '0;
  logic [N-1:0] eu_ready;
  cdb_data_t eu_data [N];
  logic      cdb_valid;
  cdb_data_t cdb_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.EU_N(N)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .eu_valid_i  (eu_valid),
    .eu_ready_o  (eu_ready),
    .eu_data_i   (eu_data),
    .cdb_valid_o (cdb_valid),
    .cdb_ready_i (cdb_ready),
    .cdb_data_o  (cdb_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic cdb_data_t mk(input int rob, input int val);
    cdb_data_t d;
    d = '0;
    d.rob_idx = 6'(rob);
    d.value   = 32'(val);
    return d;
  endfunction

  task automatic default_data();
    for (int i = 0; i < N; i++) eu_data[i] = mk(10 + i, 32'h100 + i);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    flush = 1'b0;
    eu_valid = '0;
    cdb_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference: grant the first valid requester at or after ptr, modulo N.
  function automatic logic [N-1:0] model_grant(input int ptr, input logic [N-1:0] v,
                                               input logic free, input logic fl);
    logic [N-1:0] g;
    int idx;
    bit found;
    g = '0;
    found = 0;
    if (free && !fl) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (!found && v[idx]) begin
          g[idx] = 1'b1;
          found = 1;
        end
      end
    end
    return g;
  endfunction

  typedef struct {
    logic       fl;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] exp_gnt;
    logic       exp_cv;
    logic [5:0] exp_rob;
  } vec_t;

  vec_t tbl [20];

  // random-phase model state
  bit        m_valid;
  cdb_data_t m_data;
  int        m_ptr;
  bit        pend [N];
  cdb_data_t pdata [N];

  initial begin
    logic [N-1:0] eg;
    int g;

    tbl[0]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 6'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 6'd12};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 6'd13};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 6'd10};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 6'd11};
    tbl[5]  = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 6'd12};
    tbl[6]  = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 6'd13};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 6'd10};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 6'd0};
    tbl[9]  = '{1'b0, 4'b0101, 1'b0, 4'b0100, 1'b0, 6'd0};
    tbl[10] = '{1'b0, 4'b0101, 1'b0, 4'b0000, 1'b1, 6'd12};
    tbl[11] = '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b1, 6'd12};
    tbl[12] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b0, 6'd0};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 6'd10};
    tbl[14] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 6'd0};
    tbl[15] = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, 6'd12};
    tbl[16] = '{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b0, 6'd0};
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 6'd12};
    tbl[18] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'd0};
    tbl[19] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 6'd0};

    default_data();

    // Reset state, with requests present
    rst_n = 1'b0;
    eu_valid = 4'b1111;
    cdb_ready = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(eu_ready), 64'h0);
    chk("reset_valid", 64'(cdb_valid), 64'h0);
    chk("reset_data", 64'(cdb_data), 64'h0);
    reset_dut();

    // Single request from unit 2, then priority pointer must sit at 3
    eu_data[2] = mk(5, 32'hAB);
    eu_valid = 4'b0100;
    cdb_ready = 1'b1;
    @(negedge clk);
    chk("t1_grant", 64'(eu_ready), 64'b0100);
    @(posedge clk); #1;
    eu_valid = 4'b0000;
    @(negedge clk);
    chk("t1_valid", 64'(cdb_valid), 64'h1);
    chk("t1_rob", 64'(cdb_data.rob_idx), 64'd5);
    chk("t1_value", 64'(cdb_data.value), 64'hAB);
    @(posedge clk); #1;
    eu_valid = 4'b1111;
    @(negedge clk);
    chk("t1_ptr3_grant", 64'(eu_ready), 64'b1000);

    // Table-driven vectors
    reset_dut();
    default_data();
    for (int r = 0; r < 20; r++) begin
      flush = tbl[r].fl;
      eu_valid = tbl[r].req;
      cdb_ready = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", r), 64'(eu_ready), 64'(tbl[r].exp_gnt));
      chk($sformatf("tbl%0d_cv", r), 64'(cdb_valid), 64'(tbl[r].exp_cv));
      if (tbl[r].exp_cv) chk($sformatf("tbl%0d_rob", r), 64'(cdb_data.rob_idx), 64'(tbl[r].exp_rob));
      @(posedge clk); #1;
    end
    flush = 1'b0;
    eu_valid = '0;

    // Backpressure for 3 cycles, then pop and grant unit 1 together
    reset_dut();
    eu_valid = 4'b0001;
    cdb_ready = 1'b1;
    @(posedge clk); #1;
    eu_valid = 4'b0110;
    cdb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", c), 64'(eu_ready), 64'h0);
      chk($sformatf("bp%0d_valid", c), 64'(cdb_valid), 64'h1);
      chk($sformatf("bp%0d_data", c), 64'(cdb_data), 64'(mk(10, 32'h100)));
      @(posedge clk); #1;
    end
    cdb_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 64'(eu_ready), 64'b0010);
    @(posedge clk); #1;
    eu_valid = 4'b0100;
    @(negedge clk);
    chk("bp_after_rob", 64'(cdb_data.rob_idx), 64'd11);
    chk("bp_next_grant", 64'(eu_ready), 64'b0100);
    @(posedge clk); #1;
    eu_valid = '0;
    @(negedge clk);
    chk("bp_last_rob", 64'(cdb_data.rob_idx), 64'd12);

    // Asynchronous reset pulse in the middle of backpressure
    reset_dut();
    eu_valid = 4'b0001;
    cdb_ready = 1'b1;
    @(posedge clk); #1;
    eu_valid = 4'b0101;
    cdb_ready = 1'b0;
    #1;
    chk("ar_pre_valid", 64'(cdb_valid), 64'h1);
    chk("ar_pre_ready", 64'(eu_ready), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", 64'(cdb_valid), 64'h0);
    chk("ar_ready_low", 64'(eu_ready), 64'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_lowest_grant", 64'(eu_ready), 64'b0001);
    @(posedge clk); #1;
    eu_valid = '0;
    @(negedge clk);
    chk("ar_out_valid", 64'(cdb_valid), 64'h1);
    chk("ar_out_rob", 64'(cdb_data.rob_idx), 64'd10);

    // Randomized run against the behavioural model
    reset_dut();
    m_valid = 0;
    m_data = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      pdata[i] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1;
          pdata[i].rob_idx = 6'($urandom);
          pdata[i].value = $urandom;
          pdata[i].except_raised = 1'($urandom);
          pdata[i].except_code = 5'($urandom);
        end
        eu_valid[i] = pend[i];
        eu_data[i] = pdata[i];
      end
      cdb_ready = ($urandom_range(0, 99) < 65);
      flush = ($urandom_range(0, 99) < 4);
      @(negedge clk);
      eg = model_grant(m_ptr, eu_valid, !m_valid || cdb_ready, flush);
      chk("rnd_grant", 64'(eu_ready), 64'(eg));
      chk("rnd_valid", 64'(cdb_valid), 64'(m_valid));
      if (m_valid) chk("rnd_data", 64'(cdb_data), 64'(m_data));
      if (flush) begin
        m_valid = 0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
      end else if (eg != 0) begin
        g = $clog2(int'(eg));
        m_valid = 1;
        m_data = pdata[g];
        pend[g] = 0;
        m_ptr = (g + 1) % N;
      end else if (m_valid && cdb_ready) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
